// File: rtl/mxpl_pkg.sv
// Shared constants and elaboration helpers for the pooling unit.
package mxpl_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  // Channel-index width; a single-channel build still carries a 1-bit index.
  function automatic int chw(input int nch);
    return (nch > 1) ? clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/mxpl_pool_unit_if.sv
// Sample stream in, pooled result stream out, for mxpl_pool_unit.
interface mxpl_pool_unit_if #(
  parameter int DATAW = 20,
  parameter int NCH   = 4
);

  localparam int CHW = mxpl_pkg::chw(NCH);

  logic                    in_valid;
  logic [CHW-1:0]          in_ch;
  logic signed [DATAW-1:0] in_data;
  logic                    mode;
  logic                    clear;

  logic                    out_valid;
  logic [CHW-1:0]          out_ch;
  logic signed [DATAW-1:0] out_data;
  logic                    ch_err;

  modport master (
    output in_valid, in_ch, in_data, mode, clear,
    input  out_valid, out_ch, out_data, ch_err
  );

  modport slave (
    input  in_valid, in_ch, in_data, mode, clear,
    output out_valid, out_ch, out_data, ch_err
  );

endinterface

// File: rtl/mxpl_pool_lane.sv
// One channel's pooling window: sample count, latched mode, running max and sum.
module mxpl_pool_lane
  import mxpl_pkg::*;
#(
  parameter int DATAW = 20,
  parameter int WIN   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    hit,
  input  logic signed [DATAW-1:0] in_data,
  input  logic                    mode,
  output logic                    done,
  output logic signed [DATAW-1:0] result
);

  localparam int CW = clog2(WIN);
  localparam int SW = DATAW + CW;
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  logic [CW-1:0]           cnt;
  mode_e                   mode_q;
  logic signed [DATAW-1:0] max_q;
  logic signed [DATAW-1:0] max_next;
  logic signed [SW-1:0]    sum_q;
  logic signed [SW-1:0]    sum_next;
  logic signed [SW-1:0]    in_ext;
  logic signed [DATAW-1:0] avg;

  assign in_ext   = {{CW{in_data[DATAW-1]}}, in_data};
  assign max_next = (in_data > max_q) ? in_data : max_q;
  assign sum_next = sum_q + in_ext;
  // Arithmetic shift floors toward -inf; the sum is wide enough that the
  // truncated quotient always fits DATAW.
  assign avg      = DATAW'(sum_next >>> CW);

  // The completing sample is never a window's first, so mode_q is already valid.
  assign done   = hit && (cnt == LAST);
  assign result = (mode_q == MODE_AVG) ? avg : max_next;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  // NOTE: max/sum are reset as well so the lane powers up in a defined state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mode_q <= MODE_MAX;
      max_q  <= '0;
      sum_q  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (hit) begin
      if (cnt == '0) begin
        mode_q <= mode_e'(mode);
        max_q  <= in_data;
        sum_q  <= in_ext;
      end else begin
        max_q <= max_next;
        sum_q <= sum_next;
      end
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mxpl_pool_unit.sv
// Multi-channel max/average pooling accumulator with per-channel windows.
module mxpl_pool_unit
  import mxpl_pkg::*;
#(
  parameter int DATAW = 20,
  parameter int WIN   = 4,
  parameter int NCH   = 4
) (
  input logic              clk,
  input logic              reset,
  mxpl_pool_unit_if.slave  bus
);

  localparam int CHW = chw(NCH);

  logic                    accept;
  logic                    bad_ch;
  logic [NCH-1:0]          hit;
  logic [NCH-1:0]          done;
  logic signed [DATAW-1:0] lane_result [NCH];
  logic signed [DATAW-1:0] pool_data;

  // A clear in the same cycle as a sample drops the sample entirely.
  assign accept = bus.in_valid && !bus.clear;
  assign bad_ch = accept && ({1'b0, bus.in_ch} >= (CHW + 1)'(NCH));

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    assign hit[i] = accept && (bus.in_ch == CHW'(i));

    mxpl_pool_lane #(
      .DATAW (DATAW),
      .WIN   (WIN)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .flush   (bus.clear),
      .hit     (hit[i]),
      .in_data (bus.in_data),
      .mode    (bus.mode),
      .done    (done[i]),
      .result  (lane_result[i])
    );
  end

  // Only the addressed lane can complete, so done is at most one-hot.
  // NOTE: defaulting before the loop keeps this purely combinational.
  always_comb begin
    pool_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (done[i]) pool_data = pool_data | lane_result[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
      bus.ch_err    <= 1'b0;
    end else begin
      bus.out_valid <= |done;
      bus.ch_err    <= bad_ch;
      if (|done) begin
        bus.out_ch   <= bus.in_ch;
        bus.out_data <= pool_data;
      end
    end
  end

endmodule

// File: tb/tb_mxpl_pool_unit.sv
// Directed bench: three pooling-unit builds (NCH=1, NCH=3, WIN=2) sharing clk/reset.
module tb_mxpl_pool_unit;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mxpl_pool_unit_if #(.DATAW(20), .NCH(1)) if1 ();
  mxpl_pool_unit_if #(.DATAW(20), .NCH(3)) if3 ();
  mxpl_pool_unit_if #(.DATAW(20), .NCH(1)) if2 ();

  mxpl_pool_unit #(.DATAW(20), .WIN(4), .NCH(1)) u_one (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  mxpl_pool_unit #(.DATAW(20), .WIN(4), .NCH(3)) u_three (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  mxpl_pool_unit #(.DATAW(20), .WIN(2), .NCH(1)) u_win2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put1(input logic v, input logic c, input logic [0:0] ch,
                      input int data, input logic m);
    if1.in_valid = v;
    if1.clear    = c;
    if1.in_ch    = ch;
    if1.in_data  = data[19:0];
    if1.mode     = m;
    tick();
    if1.in_valid = 1'b0;
    if1.clear    = 1'b0;
  endtask

  task automatic put3(input logic v, input logic c, input logic [1:0] ch,
                      input int data, input logic m);
    if3.in_valid = v;
    if3.clear    = c;
    if3.in_ch    = ch;
    if3.in_data  = data[19:0];
    if3.mode     = m;
    tick();
    if3.in_valid = 1'b0;
    if3.clear    = 1'b0;
  endtask

  task automatic put2(input int data, input logic m);
    if2.in_valid = 1'b1;
    if2.clear    = 1'b0;
    if2.in_ch    = 1'b0;
    if2.in_data  = data[19:0];
    if2.mode     = m;
    tick();
    if2.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    {if1.in_valid, if1.clear, if1.in_ch, if1.in_data, if1.mode} = '0;
    {if3.in_valid, if3.clear, if3.in_ch, if3.in_data, if3.mode} = '0;
    {if2.in_valid, if2.clear, if2.in_ch, if2.in_data, if2.mode} = '0;

    // Reset state
    #1;
    check("rst_valid", if1.out_valid, 0);
    check("rst_ch", if1.out_ch, 0);
    check("rst_data", if1.out_data, 0);
    check("rst_err", if1.ch_err, 0);
    check("rst_valid3", if3.out_valid, 0);
    check("rst_valid2", if2.out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Max window: -5, 3, -7, 2 -> 3
    put1(1, 0, 0, -5, 0);
    check("max_s1_valid", if1.out_valid, 0);
    put1(1, 0, 0, 3, 0);
    put1(1, 0, 0, -7, 0);
    check("max_s3_valid", if1.out_valid, 0);
    put1(1, 0, 0, 2, 0);
    check("max_valid", if1.out_valid, 1);
    check("max_data", if1.out_data, 3);
    check("max_ch", if1.out_ch, 0);
    tick();
    check("max_pulse_end", if1.out_valid, 0);
    check("max_data_hold", if1.out_data, 3);

    // Average windows, back to back
    put1(1, 0, 0, 1, 1);
    put1(1, 0, 0, 2, 1);
    put1(1, 0, 0, 3, 1);
    put1(1, 0, 0, 4, 1);
    check("avg_pos_valid", if1.out_valid, 1);
    check("avg_pos_data", if1.out_data, 2);
    put1(1, 0, 0, -1, 1);
    check("avg_b2b_valid", if1.out_valid, 0);
    put1(1, 0, 0, -2, 1);
    put1(1, 0, 0, -3, 1);
    put1(1, 0, 0, -4, 1);
    check("avg_neg_data", if1.out_data, -3);
    for (int i = 0; i < 4; i++) put1(1, 0, 0, 524287, 1);
    check("avg_fs_pos_valid", if1.out_valid, 1);
    check("avg_fs_pos_data", if1.out_data, 524287);
    for (int i = 0; i < 4; i++) put1(1, 0, 0, -524288, 1);
    check("avg_fs_neg_data", if1.out_data, -524288);

    // Mode latched on first sample only
    put1(1, 0, 0, 0, 1);
    put1(1, 0, 0, 0, 0);
    put1(1, 0, 0, 0, 0);
    put1(1, 0, 0, 8, 0);
    check("latch_valid", if1.out_valid, 1);
    check("latch_data", if1.out_data, 2);

    // NCH=1: in_ch=1 is out of range
    put1(1, 0, 1, 77, 0);
    check("err1_pulse", if1.ch_err, 1);
    check("err1_no_out", if1.out_valid, 0);
    tick();
    check("err1_end", if1.ch_err, 0);

    // Clear discards a partial window
    put1(1, 0, 0, 5, 0);
    put1(1, 0, 0, 9, 0);
    put1(0, 1, 0, 0, 0);
    put1(1, 0, 0, 7, 0);
    put1(1, 0, 0, 7, 0);
    check("clr_no_early", if1.out_valid, 0);
    put1(1, 0, 0, 7, 0);
    put1(1, 0, 0, 7, 0);
    check("clr_valid", if1.out_valid, 1);
    check("clr_data", if1.out_data, 7);

    // Clear coincident with a sample drops the sample
    put1(1, 0, 0, 1, 0);
    put1(1, 0, 0, 1, 0);
    put1(1, 0, 0, 1, 0);
    put1(1, 1, 0, 100, 0);
    check("clrv_no_out", if1.out_valid, 0);
    put1(1, 0, 0, 6, 0);
    put1(1, 0, 0, 6, 0);
    put1(1, 0, 0, 6, 0);
    check("clrv_no_early", if1.out_valid, 0);
    put1(1, 0, 0, 6, 0);
    check("clrv_valid", if1.out_valid, 1);
    check("clrv_data", if1.out_data, 6);

    // Interleaved channels on the NCH=3 build
    put3(1, 0, 0, 10, 0);
    put3(1, 0, 1, 1, 1);
    put3(1, 0, 0, 20, 0);
    put3(1, 0, 1, 1, 1);
    put3(1, 0, 0, 30, 0);
    put3(1, 0, 1, 1, 1);
    check("il_no_early", if3.out_valid, 0);
    put3(1, 0, 0, 40, 0);
    check("il_ch0_valid", if3.out_valid, 1);
    check("il_ch0_ch", if3.out_ch, 0);
    check("il_ch0_data", if3.out_data, 40);
    put3(1, 0, 1, 5, 1);
    check("il_ch1_valid", if3.out_valid, 1);
    check("il_ch1_ch", if3.out_ch, 1);
    check("il_ch1_data", if3.out_data, 2);
    tick();
    check("il_end", if3.out_valid, 0);

    // Bad channel on NCH=3; clear suppresses the error
    put3(1, 1, 3, 5, 0);
    check("err3_clr_quiet", if3.ch_err, 0);
    put3(1, 0, 2, 100, 0);
    put3(1, 0, 2, 200, 0);
    put3(1, 0, 3, 999, 0);
    check("err3_pulse", if3.ch_err, 1);
    check("err3_no_out", if3.out_valid, 0);
    put3(1, 0, 2, 300, 0);
    check("err3_end", if3.ch_err, 0);
    check("err3_no_early", if3.out_valid, 0);
    put3(1, 0, 2, 50, 0);
    check("err3_valid", if3.out_valid, 1);
    check("err3_ch", if3.out_ch, 2);
    check("err3_data", if3.out_data, 300);

    // WIN=2 boundary build
    put2(3, 1);
    check("w2_first", if2.out_valid, 0);
    put2(4, 1);
    check("w2_avg_valid", if2.out_valid, 1);
    check("w2_avg_data", if2.out_data, 3);
    put2(-1, 1);
    check("w2_b2b", if2.out_valid, 0);
    put2(-2, 1);
    check("w2_avg_neg", if2.out_data, -2);
    put2(5, 0);
    put2(-9, 0);
    check("w2_max_data", if2.out_data, 5);

    // Async reset mid-window
    put1(1, 0, 0, 60, 0);
    put1(1, 0, 0, 60, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_data", if1.out_data, 0);
    check("arst_err", if1.ch_err, 0);
    check("arst_data3", if3.out_data, 0);
    #2;
    reset = 1'b0;
    put1(1, 0, 0, -3, 0);
    put1(1, 0, 0, -3, 0);
    check("arst_fresh", if1.out_valid, 0);
    put1(1, 0, 0, -3, 0);
    put1(1, 0, 0, -3, 0);
    check("arst_valid", if1.out_valid, 1);
    check("arst_result", if1.out_data, -3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
